// File: rtl/ship_multishot.sv
// ============================================================================
// ship_multishot
//   Player ship with a pool of independent bullets, fire cooldown and
//   configurable speeds; advances one step per animation tick.
//   Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module ship_multishot #(
   parameter int H_SIZE   = 80,
   parameter int B_SIZE   = 20,
   parameter int IX       = 320,
   parameter int IY       = 240,
   parameter int D_WIDTH  = 640,
   parameter int D_HEIGHT = 480,
   parameter int SPEED    = 2,
   parameter int B_SPEED  = 3,
   parameter int N_BUL    = 4,
   parameter int COOLDOWN = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_ani_stb,
   input  logic                  i_animate,
   input  logic                  i_paused,
   input  logic [7:0]            i_sw,
   output logic [11:0]           o_x1,
   output logic [11:0]           o_x2,
   output logic [11:0]           o_y1,
   output logic [11:0]           o_y2,
   output logic [12*N_BUL-1:0]   o_bx1,
   output logic [12*N_BUL-1:0]   o_bx2,
   output logic [12*N_BUL-1:0]   o_by1,
   output logic [12*N_BUL-1:0]   o_by2,
   output logic [N_BUL-1:0]      o_active,
   output logic                  o_fire
);

   localparam int CW = $clog2(COOLDOWN + 1);
   localparam logic [12:0] C_X_LO = 13'(H_SIZE);
   localparam logic [12:0] C_X_HI = 13'(D_WIDTH - H_SIZE);
   localparam logic [12:0] C_Y_LO = 13'(H_SIZE);
   localparam logic [12:0] C_Y_HI = 13'(D_HEIGHT - H_SIZE);

   logic                tick;
   logic                spawn;
   logic [N_BUL-1:0]    free_slots;
   logic [N_BUL-1:0]    spawn_oh;

   logic [11:0]         x_q, x_d, y_q, y_d;
   logic [CW-1:0]       cd_q, cd_d;
   logic                fire_q, fire_d;
   logic [N_BUL-1:0]    active_q, active_d;
   logic [11:0]         bx_q [N_BUL];
   logic [11:0]         bx_d [N_BUL];
   logic [11:0]         by_q [N_BUL];
   logic [11:0]         by_d [N_BUL];

   // One axis step with saturation; 13-bit math keeps the low clamp free of underflow.
   function automatic logic [11:0] step_axis(input logic [11:0] p, input logic inc,
                                             input logic dec, input logic [12:0] lo,
                                             input logic [12:0] hi);
      logic [12:0] pe;
      pe = {1'b0, p};
      step_axis = p;
      if (inc && !dec)
         step_axis = (pe + 13'(SPEED) > hi) ? hi[11:0] : 12'(pe + 13'(SPEED));
      else if (dec && !inc)
         step_axis = (pe < lo + 13'(SPEED)) ? lo[11:0] : 12'(pe - 13'(SPEED));
   endfunction

   assign tick       = i_animate & i_ani_stb & ~i_paused;
   assign free_slots = ~active_q;
   assign spawn_oh   = free_slots & (~free_slots + N_BUL'(1));
   assign spawn      = tick & i_sw[4] & (cd_q == '0) & (|free_slots);

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (tick) begin
         x_d = step_axis(x_q, i_sw[0], i_sw[7], C_X_LO, C_X_HI);
         y_d = step_axis(y_q, i_sw[1], i_sw[6], C_Y_LO, C_Y_HI);
      end
   end

   // Reloading COOLDOWN-1 spaces consecutive spawns exactly COOLDOWN ticks apart.
   always_comb begin
      cd_d   = cd_q;
      fire_d = spawn;
      if (tick) begin
         if (spawn)
            cd_d = CW'(COOLDOWN - 1);
         else if (cd_q != '0)
            cd_d = cd_q - CW'(1);
      end
   end

   always_comb begin
      active_d = active_q;
      for (int k = 0; k < N_BUL; k++) begin
         bx_d[k] = bx_q[k];
         by_d[k] = by_q[k];
         if (tick) begin
            if (spawn && spawn_oh[k]) begin
               active_d[k] = 1'b1;
               bx_d[k]     = x_q;
               by_d[k]     = y_q - 12'(H_SIZE);
            end else if (active_q[k]) begin
               if (by_q[k] <= 12'(B_SIZE + B_SPEED)) begin
                  active_d[k] = 1'b0;
                  bx_d[k]     = x_d;
                  by_d[k]     = y_d;
               end else begin
                  by_d[k] = by_q[k] - 12'(B_SPEED);
               end
            end else begin
               bx_d[k] = x_d;
               by_d[k] = y_d;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         x_q      <= 12'(IX);
         y_q      <= 12'(IY);
         cd_q     <= '0;
         fire_q   <= 1'b0;
         active_q <= '0;
         for (int k = 0; k < N_BUL; k++) begin
            bx_q[k] <= 12'(IX);
            by_q[k] <= 12'(IY);
         end
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         cd_q     <= cd_d;
         fire_q   <= fire_d;
         active_q <= active_d;
         for (int k = 0; k < N_BUL; k++) begin
            bx_q[k] <= bx_d[k];
            by_q[k] <= by_d[k];
         end
      end
   end

   assign o_x1     = x_q - 12'(H_SIZE);
   assign o_x2     = x_q + 12'(H_SIZE);
   assign o_y1     = y_q - 12'(H_SIZE);
   assign o_y2     = y_q + 12'(H_SIZE);
   assign o_active = active_q;
   assign o_fire   = fire_q;

   generate
      for (genvar k = 0; k < N_BUL; k++) begin : g_bul_out
         assign o_bx1[12*k +: 12] = bx_q[k] - 12'(B_SIZE);
         assign o_bx2[12*k +: 12] = bx_q[k] + 12'(B_SIZE);
         assign o_by1[12*k +: 12] = by_q[k] - 12'(B_SIZE);
         assign o_by2[12*k +: 12] = by_q[k] + 12'(B_SIZE);
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ship_multishot.sv
// ============================================================================
// tb_ship_multishot
//   Scoreboard bench: stimulus queues expected spawns and snapshots, a
//   negedge monitor pops and compares them against the ship outputs.
//   Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ship_multishot;

   localparam int N_BUL = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                stb = 1'b0;
   logic                animate = 1'b1;
   logic                paused = 1'b0;
   logic [7:0]          sw = 8'h00;
   logic [11:0]         x1, x2, y1, y2;
   logic [12*N_BUL-1:0] bx1, bx2, by1, by2;
   logic [N_BUL-1:0]    active;
   logic                fire;

   always #5 clk = ~clk;

   ship_multishot #(
      .H_SIZE(80), .B_SIZE(20), .IX(320), .IY(240), .D_WIDTH(640), .D_HEIGHT(480),
      .SPEED(2), .B_SPEED(3), .N_BUL(N_BUL), .COOLDOWN(8)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_ani_stb(stb), .i_animate(animate), .i_paused(paused),
      .i_sw(sw), .o_x1(x1), .o_x2(x2), .o_y1(y1), .o_y2(y2),
      .o_bx1(bx1), .o_bx2(bx2), .o_by1(by1), .o_by2(by2),
      .o_active(active), .o_fire(fire)
   );

   typedef struct packed {
      logic [3:0]  slot;
      logic [11:0] bx1, bx2, by1, by2;
   } fire_t;

   typedef struct packed {
      logic [11:0] x1, x2, y1, y2;
      logic [3:0]  act;
      logic        chk_by0;
      logic [11:0] by0;
   } snap_t;

   fire_t fire_q[$];
   snap_t snap_q[$];
   string name_q[$];
   logic  chk_stb = 1'b0;
   int    n_cmp = 0;
   int    n_bad = 0;

   fire_t fe;
   snap_t se;
   string nm;
   int    m_idx;

   always @(negedge clk) begin
      if (fire === 1'b1) begin
         n_cmp++;
         if (fire_q.size() == 0) begin
            n_bad++;
            $display("FAIL spawn_unexpected: o_fire=1 o_active=%h, required no spawn", active);
         end else begin
            fe    = fire_q.pop_front();
            m_idx = int'(fe.slot);
            if (active[m_idx] !== 1'b1 || bx1[12*m_idx +: 12] !== fe.bx1 ||
                bx2[12*m_idx +: 12] !== fe.bx2 || by1[12*m_idx +: 12] !== fe.by1 ||
                by2[12*m_idx +: 12] !== fe.by2) begin
               n_bad++;
               $display("FAIL spawn_slot%0d: act=%b box=%0d/%0d/%0d/%0d required act=1 box=%0d/%0d/%0d/%0d",
                        m_idx, active[m_idx], bx1[12*m_idx +: 12], bx2[12*m_idx +: 12],
                        by1[12*m_idx +: 12], by2[12*m_idx +: 12], fe.bx1, fe.bx2, fe.by1, fe.by2);
            end
         end
      end
      if (chk_stb) begin
         se = snap_q.pop_front();
         nm = name_q.pop_front();
         n_cmp++;
         if (x1 !== se.x1 || x2 !== se.x2 || y1 !== se.y1 || y2 !== se.y2 ||
             active !== se.act || fire !== 1'b0 ||
             (se.chk_by0 && by1[11:0] !== se.by0)) begin
            n_bad++;
            $display("FAIL %s: ship=%0d/%0d/%0d/%0d act=%h fire=%b by0_top=%0d required ship=%0d/%0d/%0d/%0d act=%h fire=0 by0_top=%0d",
                     nm, x1, x2, y1, y2, active, fire, by1[11:0],
                     se.x1, se.x2, se.y1, se.y2, se.act, se.by0);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk); stb = 1'b1;
         @(negedge clk); stb = 1'b0;
      end
   endtask

   task automatic push_fire(input int slot, input int bx, input int by);
      fire_t f;
      f.slot = 4'(slot);
      f.bx1 = 12'(bx - 20); f.bx2 = 12'(bx + 20);
      f.by1 = 12'(by - 20); f.by2 = 12'(by + 20);
      fire_q.push_back(f);
   endtask

   task automatic expect_snap(input string name, input int x, input int y,
                              input logic [3:0] act, input logic chk, input int by0);
      snap_t s;
      s.x1 = 12'(x - 80); s.x2 = 12'(x + 80);
      s.y1 = 12'(y - 80); s.y2 = 12'(y + 80);
      s.act = act; s.chk_by0 = chk; s.by0 = 12'(by0 - 20);
      @(posedge clk); #1;
      snap_q.push_back(s);
      name_q.push_back(name);
      chk_stb = 1'b1;
      @(negedge clk); #1;
      chk_stb = 1'b0;
   endtask

   initial begin
      // Strobe held during reset: reset must win.
      stb = 1'b1; sw = 8'h01;
      repeat (3) @(negedge clk);
      rst = 1'b0; stb = 1'b0; sw = 8'h00;
      expect_snap("reset", 320, 240, 4'h0, 1'b1, 240);

      sw = 8'h01; step(10);
      expect_snap("right_10", 340, 240, 4'h0, 1'b0, 0);
      step(200);
      expect_snap("right_clamp", 560, 240, 4'h0, 1'b0, 0);
      sw = 8'h81; step(10);
      expect_snap("lr_both", 560, 240, 4'h0, 1'b0, 0);
      sw = 8'h80; step(5);
      expect_snap("left_5", 550, 240, 4'h0, 1'b0, 0);
      sw = 8'h40; step(100);
      expect_snap("up_clamp", 550, 80, 4'h0, 1'b0, 0);
      sw = 8'h02; step(200);
      expect_snap("down_clamp", 550, 400, 4'h0, 1'b0, 0);
      sw = 8'h40; step(80);
      sw = 8'h80; step(115);
      expect_snap("recentre", 320, 240, 4'h0, 1'b1, 240);

      paused = 1'b1; sw = 8'hFF; step(20);
      expect_snap("paused", 320, 240, 4'h0, 1'b1, 240);
      paused = 1'b0;

      sw = 8'h10;
      for (int t = 0; t < 32; t++) begin
         if (t % 8 == 0) push_fire(t / 8, 320, 160);
         step(1);
      end
      expect_snap("pool_full", 320, 240, 4'hF, 1'b1, 67);
      step(15);
      expect_snap("slot0_by22", 320, 240, 4'hF, 1'b1, 22);
      step(1);
      expect_snap("slot0_retire", 320, 240, 4'hE, 1'b1, 240);
      push_fire(0, 320, 160);
      step(1);
      expect_snap("slot0_respawn", 320, 240, 4'hF, 1'b1, 160);
      sw = 8'h00;

      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      expect_snap("reset2", 320, 240, 4'h0, 1'b1, 240);
      sw = 8'h10;
      for (int t = 0; t < 30; t++) begin
         if (t % 8 == 0) push_fire(t / 8, 320, 160);
         step(1);
      end
      @(negedge clk); rst = 1'b1; stb = 1'b1;
      @(negedge clk); rst = 1'b0; stb = 1'b0; sw = 8'h00;
      expect_snap("reset_midflight", 320, 240, 4'h0, 1'b1, 240);

      repeat (4) @(negedge clk);
      if (fire_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL spawn_missing: %0d pending spawns, required 0", fire_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
